// File: rtl/neighbor_builder.sv
`default_nettype none
// ============================================================================
// Module   : neighbor_builder
// Purpose  : Clears the neighbour table, then inserts every directed edge of
//            every triangle into its destination row without duplicates.
// Option   : NEIGHBOR_BUILDER_DROP_CNT_EN enables the saturating drop counter.
// Revision : 1.0
// ============================================================================
module neighbor_builder #(
  parameter int MAX_NEIGHBOR_COUNT = 10,
  parameter int FACE_BASE          = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] vertex_count,
  input  logic [31:0] face_count,
  input  logic [31:0] RAM_FACE_Do,
  output logic        RAM_FACE_EN,
  output logic [8:0]  RAM_FACE_A,
  input  logic [31:0] RAM_NBR_Do,
  output logic        RAM_NBR_EN,
  output logic [8:0]  RAM_NBR_A,
  output logic [3:0]  RAM_NBR_WE,
  output logic [31:0] RAM_NBR_Di,
  output logic        busy,
  output logic        done,
  output logic        overflow,
  output logic        err,
  output logic [15:0] drop_count
);

  localparam logic [8:0]  c_max9    = 9'(MAX_NEIGHBOR_COUNT);
  localparam logic [8:0]  c_max_m1  = 9'(MAX_NEIGHBOR_COUNT - 1);
  localparam logic [63:0] c_max64   = 64'(MAX_NEIGHBOR_COUNT);
  localparam logic [8:0]  c_base9   = 9'(FACE_BASE);

  typedef enum logic [3:0] {
    IDLE, CHECK, CLEAR, FACE_RD, EDGE_SEL, CNT_RD, SCAN, APPEND, DONE
  } state_t;

  state_t      r_state;
  logic [31:0] r_vtx;
  logic [31:0] r_face;
  logic [2:0]  r_k;
  logic [2:0]  r_edge;
  logic        r_bad;
  logic [8:0]  r_a, r_b, r_c;
  logic [8:0]  r_row, r_nbr, r_cnt, r_j;

  logic [8:0]  w_dst, w_nbr;
  logic [8:0]  w_face_addr;
  logic [63:0] w_need;
  logic        w_too_big;
  logic        w_idx_bad;

`ifdef NEIGHBOR_BUILDER_DROP_CNT_EN
  logic [15:0] r_drop_count;
  assign drop_count = r_drop_count;
`else
  assign drop_count = 16'h0000;
`endif

  function automatic logic [8:0] row_of(input logic [8:0] v);
    return (v - 9'd1) * c_max9;
  endfunction

  assign w_face_addr = c_base9 + r_face[8:0] * 9'd3;
  assign w_need      = {32'd0, vertex_count} * c_max64;
  assign w_too_big   = (w_need > 64'd512);
  assign w_idx_bad   = (RAM_FACE_Do == 32'd0) || (RAM_FACE_Do > vertex_count);

  // Edge order a->b, a->c, b->a, b->c, c->a, c->b as (dst, nbr)
  always_comb begin
    w_dst = r_a;
    w_nbr = r_a;
    case (r_edge)
      3'd0: begin w_dst = r_a; w_nbr = r_b; end
      3'd1: begin w_dst = r_a; w_nbr = r_c; end
      3'd2: begin w_dst = r_b; w_nbr = r_a; end
      3'd3: begin w_dst = r_b; w_nbr = r_c; end
      3'd4: begin w_dst = r_c; w_nbr = r_a; end
      3'd5: begin w_dst = r_c; w_nbr = r_b; end
      default: begin w_dst = r_a; w_nbr = r_a; end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      RAM_FACE_EN <= 1'b0;
      RAM_FACE_A  <= '0;
      RAM_NBR_EN  <= 1'b0;
      RAM_NBR_A   <= '0;
      RAM_NBR_WE  <= 4'b0000;
      RAM_NBR_Di  <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      overflow    <= 1'b0;
      err         <= 1'b0;
      r_vtx       <= '0;
      r_face      <= '0;
      r_k         <= '0;
      r_edge      <= '0;
      r_bad       <= 1'b0;
      r_a         <= '0;
      r_b         <= '0;
      r_c         <= '0;
      r_row       <= '0;
      r_nbr       <= '0;
      r_cnt       <= '0;
      r_j         <= '0;
`ifdef NEIGHBOR_BUILDER_DROP_CNT_EN
      r_drop_count <= '0;
`endif
    end else begin
      done       <= 1'b0;
      RAM_NBR_WE <= 4'b0000;
      case (r_state)
        IDLE: begin
          if (start) begin
            overflow    <= 1'b0;
            err         <= 1'b0;
`ifdef NEIGHBOR_BUILDER_DROP_CNT_EN
            r_drop_count <= '0;
`endif
            busy        <= 1'b1;
            RAM_FACE_EN <= 1'b1;
            RAM_NBR_EN  <= 1'b1;
            r_state     <= CHECK;
          end
        end
        CHECK: begin
          r_face <= '0;
          r_k    <= '0;
          if (w_too_big || (vertex_count == 32'd0 && face_count == 32'd0)) begin
            err         <= w_too_big;
            r_state     <= DONE;
            done        <= 1'b1;
            busy        <= 1'b0;
            RAM_FACE_EN <= 1'b0;
            RAM_NBR_EN  <= 1'b0;
          end else if (vertex_count == 32'd0) begin
            r_state <= FACE_RD;
          end else begin
            r_vtx      <= 32'd1;
            RAM_NBR_A  <= row_of(9'd1);
            RAM_NBR_Di <= '0;
            RAM_NBR_WE <= 4'b1111;
            r_state    <= CLEAR;
          end
        end
        CLEAR: begin
          if (r_vtx == vertex_count) begin
            if (face_count == 32'd0) begin
              r_state     <= DONE;
              done        <= 1'b1;
              busy        <= 1'b0;
              RAM_FACE_EN <= 1'b0;
              RAM_NBR_EN  <= 1'b0;
            end else begin
              r_state <= FACE_RD;
            end
          end else begin
            r_vtx      <= r_vtx + 32'd1;
            RAM_NBR_A  <= row_of(r_vtx[8:0] + 9'd1);
            RAM_NBR_WE <= 4'b1111;
          end
        end
        // Three pipelined reads; each word's data arrives two sub-steps after r_k=0
        FACE_RD: begin
          case (r_k)
            3'd0: begin
              if (r_face == face_count) begin
                r_state     <= DONE;
                done        <= 1'b1;
                busy        <= 1'b0;
                RAM_FACE_EN <= 1'b0;
                RAM_NBR_EN  <= 1'b0;
              end else begin
                RAM_FACE_A <= w_face_addr;
                r_k        <= 3'd1;
              end
            end
            3'd1: begin
              RAM_FACE_A <= w_face_addr + 9'd1;
              r_k        <= 3'd2;
            end
            3'd2: begin
              r_a        <= RAM_FACE_Do[8:0];
              r_bad      <= w_idx_bad;
              RAM_FACE_A <= w_face_addr + 9'd2;
              r_k        <= 3'd3;
            end
            3'd3: begin
              r_b   <= RAM_FACE_Do[8:0];
              r_bad <= r_bad | w_idx_bad;
              r_k   <= 3'd4;
            end
            default: begin
              r_c <= RAM_FACE_Do[8:0];
              r_k <= 3'd0;
              if (r_bad | w_idx_bad) begin
                err    <= 1'b1;
                r_face <= r_face + 32'd1;
              end else begin
                r_edge  <= 3'd0;
                r_state <= EDGE_SEL;
              end
            end
          endcase
        end
        EDGE_SEL: begin
          if (r_edge == 3'd6) begin
            r_face  <= r_face + 32'd1;
            r_k     <= 3'd0;
            r_state <= FACE_RD;
          end else if (w_dst == w_nbr) begin
            r_edge <= r_edge + 3'd1;
          end else begin
            r_row     <= row_of(w_dst);
            r_nbr     <= w_nbr;
            RAM_NBR_A <= row_of(w_dst);
            r_state   <= CNT_RD;
          end
        end
        CNT_RD: begin
          RAM_NBR_A <= r_row + 9'd1;
          r_j       <= '0;
          r_state   <= SCAN;
        end
        // r_j=0 sees the count word; r_j>=1 sees entry r_j while the next is addressed
        SCAN: begin
          if (r_j == 9'd0) begin
            r_cnt <= RAM_NBR_Do[8:0];
            if (RAM_NBR_Do[8:0] == 9'd0) begin
              r_k     <= 3'd0;
              r_state <= APPEND;
            end else begin
              RAM_NBR_A <= r_row + 9'd2;
              r_j       <= 9'd1;
            end
          end else if (RAM_NBR_Do == {23'd0, r_nbr}) begin
            r_edge  <= r_edge + 3'd1;
            r_state <= EDGE_SEL;
          end else if (r_j == r_cnt) begin
            r_k     <= 3'd0;
            r_state <= APPEND;
          end else begin
            RAM_NBR_A <= r_row + r_j + 9'd2;
            r_j       <= r_j + 9'd1;
          end
        end
        APPEND: begin
          case (r_k)
            3'd0: begin
              if (r_cnt >= c_max_m1) begin
                overflow <= 1'b1;
`ifdef NEIGHBOR_BUILDER_DROP_CNT_EN
                if (r_drop_count != 16'hFFFF) r_drop_count <= r_drop_count + 16'd1;
`endif
                r_edge  <= r_edge + 3'd1;
                r_state <= EDGE_SEL;
              end else begin
                RAM_NBR_A  <= r_row + r_cnt + 9'd1;
                RAM_NBR_Di <= {23'd0, r_nbr};
                RAM_NBR_WE <= 4'b1111;
                r_k        <= 3'd1;
              end
            end
            3'd1: begin
              RAM_NBR_A  <= r_row;
              RAM_NBR_Di <= {23'd0, r_cnt + 9'd1};
              RAM_NBR_WE <= 4'b1111;
              r_k        <= 3'd2;
            end
            default: begin
              r_edge  <= r_edge + 3'd1;
              r_state <= EDGE_SEL;
            end
          endcase
        end
        DONE: begin
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_neighbor_builder.sv
`default_nettype none
// tb_neighbor_builder: directed builds on small meshes, rows compared against hand-derived tables.
module tb_neighbor_builder;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  logic        start_a, face_en_a, nbr_en_a, busy_a, done_a, ovf_a, err_a;
  logic [31:0] vc_a, fc_a, face_do_a, nbr_do_a, nbr_di_a;
  logic [8:0]  face_addr_a, nbr_addr_a;
  logic [3:0]  nbr_we_a;
  logic [15:0] drop_a;

  logic        start_b, face_en_b, nbr_en_b, busy_b, done_b, ovf_b, err_b;
  logic [31:0] vc_b, fc_b, face_do_b, nbr_do_b, nbr_di_b;
  logic [8:0]  face_addr_b, nbr_addr_b;
  logic [3:0]  nbr_we_b;
  logic [15:0] drop_b;

  logic [31:0] face_mem_a [512];
  logic [31:0] nbr_mem_a  [512];
  logic [31:0] face_mem_b [512];
  logic [31:0] nbr_mem_b  [512];
  logic scrub_a = 1'b0;
  logic scrub_b = 1'b0;
  int   writes_a = 0;

  int checks = 0;
  int errors = 0;

  neighbor_builder #(.MAX_NEIGHBOR_COUNT(10), .FACE_BASE(0)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .vertex_count(vc_a), .face_count(fc_a),
    .RAM_FACE_Do(face_do_a), .RAM_FACE_EN(face_en_a), .RAM_FACE_A(face_addr_a),
    .RAM_NBR_Do(nbr_do_a), .RAM_NBR_EN(nbr_en_a), .RAM_NBR_A(nbr_addr_a),
    .RAM_NBR_WE(nbr_we_a), .RAM_NBR_Di(nbr_di_a), .busy(busy_a), .done(done_a),
    .overflow(ovf_a), .err(err_a), .drop_count(drop_a));

  neighbor_builder #(.MAX_NEIGHBOR_COUNT(4), .FACE_BASE(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .vertex_count(vc_b), .face_count(fc_b),
    .RAM_FACE_Do(face_do_b), .RAM_FACE_EN(face_en_b), .RAM_FACE_A(face_addr_b),
    .RAM_NBR_Do(nbr_do_b), .RAM_NBR_EN(nbr_en_b), .RAM_NBR_A(nbr_addr_b),
    .RAM_NBR_WE(nbr_we_b), .RAM_NBR_Di(nbr_di_b), .busy(busy_b), .done(done_b),
    .overflow(ovf_b), .err(err_b), .drop_count(drop_b));

  always @(posedge clk) begin
    if (scrub_a) begin
      for (int i = 0; i < 512; i++) nbr_mem_a[i] <= 32'hDEAD0000 | i;
    end else if (nbr_en_a) begin
      if (nbr_we_a == 4'b1111) begin
        nbr_mem_a[nbr_addr_a] <= nbr_di_a;
        writes_a <= writes_a + 1;
      end
      nbr_do_a <= nbr_mem_a[nbr_addr_a];
    end
    if (face_en_a) face_do_a <= face_mem_a[face_addr_a];
  end

  always @(posedge clk) begin
    if (scrub_b) begin
      for (int i = 0; i < 512; i++) nbr_mem_b[i] <= 32'hBEEF0000 | i;
    end else if (nbr_en_b) begin
      if (nbr_we_b == 4'b1111) nbr_mem_b[nbr_addr_b] <= nbr_di_b;
      nbr_do_b <= nbr_mem_b[nbr_addr_b];
    end
    if (face_en_b) face_do_b <= face_mem_b[face_addr_b];
  end

  // Scrubs the table, pulses start, waits (bounded) for done and counts every done pulse.
  task automatic run_a(input int vc, input int fc, input bit restart, output int dones, output bit tmo);
    scrub_a = 1'b1;
    @(negedge clk);
    scrub_a = 1'b0;
    vc_a = vc;
    fc_a = fc;
    start_a = 1'b1;
    tmo = 1'b1;
    dones = 0;
    for (int i = 0; i < 4000 && tmo; i++) begin
      @(negedge clk);
      start_a = restart && (i < 3);
      if (done_a) begin dones++; tmo = 1'b0; end
    end
    start_a = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (done_a) dones++;
    end
  endtask

  task automatic test_reset();
    checks++;
    if ({face_en_a, face_addr_a, nbr_en_a, nbr_addr_a, nbr_we_a, nbr_di_a} !== '0) begin
      errors++; $display("FAIL reset_ram_a got %h want 0", {face_en_a, face_addr_a, nbr_en_a, nbr_addr_a, nbr_we_a, nbr_di_a});
    end
    checks++;
    if ({busy_a, done_a, ovf_a, err_a, drop_a} !== '0) begin
      errors++; $display("FAIL reset_status_a got %h want 0", {busy_a, done_a, ovf_a, err_a, drop_a});
    end
    checks++;
    if ({face_en_b, face_addr_b, nbr_en_b, nbr_addr_b, nbr_we_b, nbr_di_b} !== '0) begin
      errors++; $display("FAIL reset_ram_b got %h want 0", {face_en_b, face_addr_b, nbr_en_b, nbr_addr_b, nbr_we_b, nbr_di_b});
    end
    checks++;
    if ({busy_b, done_b, ovf_b, err_b, drop_b} !== '0) begin
      errors++; $display("FAIL reset_status_b got %h want 0", {busy_b, done_b, ovf_b, err_b, drop_b});
    end
  endtask

  task automatic test_single_face();
    int d; bit t;
    int exp_rows [3][4] = '{'{2, 2, 3, 0}, '{2, 1, 3, 0}, '{2, 1, 2, 0}};
    face_mem_a[0] = 1; face_mem_a[1] = 2; face_mem_a[2] = 3;
    run_a(3, 1, 1'b0, d, t);
    checks++;
    if (t !== 1'b0) begin errors++; $display("FAIL t1_timeout got %0d want 0", t); end
    checks++;
    if (d !== 1) begin errors++; $display("FAIL t1_done_pulses got %0d want 1", d); end
    checks++;
    if ({err_a, ovf_a, busy_a} !== 3'b000) begin errors++; $display("FAIL t1_flags got %b want 000", {err_a, ovf_a, busy_a}); end
    for (int v = 0; v < 3; v++)
      for (int j = 0; j <= exp_rows[v][0]; j++) begin
        checks++;
        if (nbr_mem_a[v*10+j] !== 32'(exp_rows[v][j])) begin
          errors++; $display("FAIL t1_row v%0d w%0d got %0d want %0d", v+1, j, nbr_mem_a[v*10+j], exp_rows[v][j]);
        end
      end
  endtask

  task automatic test_shared_edge(input string tag);
    int d; bit t;
    int exp_rows [4][4] = '{'{3, 2, 3, 4}, '{2, 1, 3, 0}, '{3, 1, 2, 4}, '{2, 1, 3, 0}};
    face_mem_a[0] = 1; face_mem_a[1] = 2; face_mem_a[2] = 3;
    face_mem_a[3] = 1; face_mem_a[4] = 3; face_mem_a[5] = 4;
    run_a(4, 2, 1'b0, d, t);
    checks++;
    if (t !== 1'b0 || d !== 1) begin errors++; $display("FAIL %s_done got tmo=%0d pulses=%0d want tmo=0 pulses=1", tag, t, d); end
    checks++;
    if ({err_a, ovf_a} !== 2'b00) begin errors++; $display("FAIL %s_flags got %b want 00", tag, {err_a, ovf_a}); end
    for (int v = 0; v < 4; v++)
      for (int j = 0; j <= exp_rows[v][0]; j++) begin
        checks++;
        if (nbr_mem_a[v*10+j] !== 32'(exp_rows[v][j])) begin
          errors++; $display("FAIL %s_row v%0d w%0d got %0d want %0d", tag, v+1, j, nbr_mem_a[v*10+j], exp_rows[v][j]);
        end
      end
  endtask

  task automatic test_overflow();
    bit t = 1'b1;
    int d = 0;
    int exp_drop;
    int exp_rows [2][4] = '{'{3, 2, 3, 4}, '{2, 1, 4, 0}};
    int vrow [2] = '{0, 4};
`ifdef NEIGHBOR_BUILDER_DROP_CNT_EN
    exp_drop = 1;
`else
    exp_drop = 0;
`endif
    face_mem_b[0] = 1; face_mem_b[1] = 2; face_mem_b[2] = 3;
    face_mem_b[3] = 1; face_mem_b[4] = 3; face_mem_b[5] = 4;
    face_mem_b[6] = 1; face_mem_b[7] = 4; face_mem_b[8] = 5;
    scrub_b = 1'b1;
    @(negedge clk);
    scrub_b = 1'b0;
    vc_b = 5; fc_b = 3; start_b = 1'b1;
    for (int i = 0; i < 4000 && t; i++) begin
      @(negedge clk);
      start_b = 1'b0;
      if (done_b) begin d++; t = 1'b0; end
    end
    checks++;
    if (t !== 1'b0 || d !== 1) begin errors++; $display("FAIL t3_done got tmo=%0d pulses=%0d want tmo=0 pulses=1", t, d); end
    checks++;
    if ({ovf_b, err_b} !== 2'b10) begin errors++; $display("FAIL t3_flags got ovf/err=%b want 10", {ovf_b, err_b}); end
    checks++;
    if (drop_b !== 16'(exp_drop)) begin errors++; $display("FAIL t3_drop_count got %0d want %0d", drop_b, exp_drop); end
    for (int r = 0; r < 2; r++)
      for (int j = 0; j <= exp_rows[r][0]; j++) begin
        checks++;
        if (nbr_mem_b[vrow[r]*4+j] !== 32'(exp_rows[r][j])) begin
          errors++; $display("FAIL t3_row v%0d w%0d got %0d want %0d", vrow[r]+1, j, nbr_mem_b[vrow[r]*4+j], exp_rows[r][j]);
        end
      end
  endtask

  task automatic test_bad_face();
    int d; bit t;
    int exp_rows [4][4] = '{'{2, 2, 3, 0}, '{2, 1, 3, 0}, '{2, 1, 2, 0}, '{0, 0, 0, 0}};
    face_mem_a[0] = 1; face_mem_a[1] = 2; face_mem_a[2] = 9;
    face_mem_a[3] = 1; face_mem_a[4] = 2; face_mem_a[5] = 3;
    run_a(4, 2, 1'b0, d, t);
    checks++;
    if (t !== 1'b0 || d !== 1) begin errors++; $display("FAIL t4_done got tmo=%0d pulses=%0d want tmo=0 pulses=1", t, d); end
    checks++;
    if ({err_a, ovf_a} !== 2'b10) begin errors++; $display("FAIL t4_flags got err/ovf=%b want 10", {err_a, ovf_a}); end
    for (int v = 0; v < 4; v++)
      for (int j = 0; j <= exp_rows[v][0]; j++) begin
        checks++;
        if (nbr_mem_a[v*10+j] !== 32'(exp_rows[v][j])) begin
          errors++; $display("FAIL t4_row v%0d w%0d got %0d want %0d", v+1, j, nbr_mem_a[v*10+j], exp_rows[v][j]);
        end
      end
  endtask

  task automatic test_reset_mid();
    face_mem_a[0] = 1; face_mem_a[1] = 2; face_mem_a[2] = 3;
    face_mem_a[3] = 1; face_mem_a[4] = 3; face_mem_a[5] = 4;
    @(negedge clk);
    vc_a = 4; fc_a = 2; start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    repeat (24) @(negedge clk);
    checks++;
    if (busy_a !== 1'b1) begin errors++; $display("FAIL t5_busy_before got %b want 1", busy_a); end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({face_en_a, face_addr_a, nbr_en_a, nbr_addr_a, nbr_we_a, nbr_di_a, busy_a, done_a, ovf_a, err_a, drop_a} !== '0) begin
      errors++; $display("FAIL t5_async_reset got %h want 0",
        {face_en_a, face_addr_a, nbr_en_a, nbr_addr_a, nbr_we_a, nbr_di_a, busy_a, done_a, ovf_a, err_a, drop_a});
    end
    @(negedge clk);
    rst_n = 1'b1;
    test_shared_edge("t5");
  endtask

  task automatic test_busy_start();
    int d; bit t;
    face_mem_a[0] = 1; face_mem_a[1] = 2; face_mem_a[2] = 3;
    run_a(3, 1, 1'b1, d, t);
    checks++;
    if (t !== 1'b0 || d !== 1) begin errors++; $display("FAIL t6_single_done got tmo=%0d pulses=%0d want tmo=0 pulses=1", t, d); end
    checks++;
    if ({nbr_mem_a[0], nbr_mem_a[1], nbr_mem_a[2]} !== {32'd2, 32'd2, 32'd3}) begin
      errors++; $display("FAIL t6_row1 got %0d %0d %0d want 2 2 3", nbr_mem_a[0], nbr_mem_a[1], nbr_mem_a[2]);
    end
  endtask

  task automatic test_too_big();
    int d; bit t; int w0;
    w0 = writes_a;
    run_a(60, 1, 1'b0, d, t);
    checks++;
    if (t !== 1'b0 || d !== 1) begin errors++; $display("FAIL t6_big_done got tmo=%0d pulses=%0d want tmo=0 pulses=1", t, d); end
    checks++;
    if (err_a !== 1'b1) begin errors++; $display("FAIL t6_big_err got %b want 1", err_a); end
    checks++;
    if (writes_a - w0 !== 0) begin errors++; $display("FAIL t6_big_writes got %0d want 0", writes_a - w0); end
    checks++;
    if (nbr_mem_a[0] !== 32'hDEAD0000) begin errors++; $display("FAIL t6_big_untouched got %h want dead0000", nbr_mem_a[0]); end
  endtask

  initial begin
    for (int i = 0; i < 512; i++) begin face_mem_a[i] = '0; face_mem_b[i] = '0; end
    rst_n = 1'b0;
    start_a = 1'b0; vc_a = '0; fc_a = '0;
    start_b = 1'b0; vc_b = '0; fc_b = '0;
    repeat (3) @(negedge clk);
    test_reset();
    rst_n = 1'b1;
    @(negedge clk);
    test_single_face();
    test_shared_edge("t2");
    test_overflow();
    test_bad_face();
    test_reset_mid();
    test_busy_start();
    test_too_big();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
